// File: rtl/rv_pkg.sv
// Shared writeback definitions.
// Register index/data widths, x0 constant and the writeback entry layout.
package rv_pkg;

    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 32;
    localparam int REG_X0     = 0;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } wb_entry_t;

    // One-hot decode of a register index.
    function automatic logic [2**ADDR_WIDTH-1:0] rd_onehot(
        input logic [ADDR_WIDTH-1:0] r
    );
        logic [2**ADDR_WIDTH-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rv_wb_fifo.sv
// Small writeback FIFO for one result producer.
// Exposes a per-slot valid/rd view so the stage can build its pending mask.
module rv_wb_fifo #(
    parameter int AW    = rv_pkg::ADDR_WIDTH,
    parameter int DW    = rv_pkg::DATA_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [AW-1:0]            push_rd,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    output logic [AW-1:0]            head_rd,
    output logic [DW-1:0]            head_data,
    output logic                     empty,
    output logic                     full,
    output logic [DEPTH-1:0]         ent_valid,
    output logic [DEPTH-1:0][AW-1:0] ent_rd
);

    import rv_pkg::*;

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] mem_rd   [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full      = (count == (PW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_rd   = mem_rd[rd_ptr];
    assign head_data = mem_data[rd_ptr];

    // Pointers wrap modulo DEPTH; the extra count bit separates full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; only slots covered by count are ever observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_rd[wr_ptr]   <= push_rd;
            mem_data[wr_ptr] <= push_data;
        end
    end

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        logic [PW-1:0] off;
        off       = '0;
        ent_valid = '0;
        ent_rd    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off          = PW'(i) - rd_ptr;
            ent_valid[i] = ({1'b0, off} < count);
            ent_rd[i]    = mem_rd[i];
        end
    end

endmodule

// File: rtl/rv_wb_stage.sv
// Writeback stage: buffers ALU and LSU results and issues one
// register-file write per cycle, LSU first with an ALU anti-starvation cap.
module rv_wb_stage #(
    parameter int ADDR_WIDTH = rv_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = rv_pkg::DATA_WIDTH,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDR_WIDTH-1:0]    alu_rd,
    input  logic [DATA_WIDTH-1:0]    alu_data,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [ADDR_WIDTH-1:0]    lsu_rd,
    input  logic [DATA_WIDTH-1:0]    lsu_data,
    output logic [ADDR_WIDTH-1:0]    rd,
    output logic [DATA_WIDTH-1:0]    Rd_input,
    output logic                     we,
    output logic [2**ADDR_WIDTH-1:0] pending
);

    import rv_pkg::*;

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int NR = 2**ADDR_WIDTH;

    logic                             alu_full;
    logic                             alu_empty;
    logic                             alu_push;
    logic                             alu_pop;
    logic [ADDR_WIDTH-1:0]            alu_hrd;
    logic [DATA_WIDTH-1:0]            alu_hdata;
    logic [DEPTH-1:0]                 alu_ev;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] alu_er;

    logic                             lsu_full;
    logic                             lsu_empty;
    logic                             lsu_push;
    logic                             lsu_pop;
    logic [ADDR_WIDTH-1:0]            lsu_hrd;
    logic [DATA_WIDTH-1:0]            lsu_hdata;
    logic [DEPTH-1:0]                 lsu_ev;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] lsu_er;

    logic [SW-1:0]                    starve_cnt;
    logic                             starved;
    logic                             alu_win;
    logic                             lsu_win;
    logic [NR-1:0]                    pend;

    // Readiness depends only on FIFO occupancy, never on valid.
    assign alu_ready = !alu_full;
    assign lsu_ready = !lsu_full;

    // Writes to x0 are acknowledged but never buffered.
    assign alu_push = alu_valid && alu_ready
                   && (alu_rd != ADDR_WIDTH'(REG_X0));
    assign lsu_push = lsu_valid && lsu_ready
                   && (lsu_rd != ADDR_WIDTH'(REG_X0));

    rv_wb_fifo #(
        .AW    (ADDR_WIDTH),
        .DW    (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_alu_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (alu_push),
        .push_rd   (alu_rd),
        .push_data (alu_data),
        .pop       (alu_pop),
        .head_rd   (alu_hrd),
        .head_data (alu_hdata),
        .empty     (alu_empty),
        .full      (alu_full),
        .ent_valid (alu_ev),
        .ent_rd    (alu_er)
    );

    rv_wb_fifo #(
        .AW    (ADDR_WIDTH),
        .DW    (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_lsu_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (lsu_push),
        .push_rd   (lsu_rd),
        .push_data (lsu_data),
        .pop       (lsu_pop),
        .head_rd   (lsu_hrd),
        .head_data (lsu_hdata),
        .empty     (lsu_empty),
        .full      (lsu_full),
        .ent_valid (lsu_ev),
        .ent_rd    (lsu_er)
    );

    // LSU has priority unless the ALU has already lost STARVE_MAX times.
    assign starved = (starve_cnt == SW'(STARVE_MAX));
    assign alu_win = !alu_empty && (lsu_empty || starved);
    assign lsu_win = !lsu_empty && !alu_win;
    assign alu_pop = alu_win;
    assign lsu_pop = lsu_win;

    // Count consecutive ALU losses, saturating at the cap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (alu_empty || alu_win) begin
            starve_cnt <= '0;
        end else if (!starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Register the winning head onto the register-file write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we       <= 1'b0;
            rd       <= '0;
            Rd_input <= '0;
        end else begin
            unique case (1'b1)
                alu_win: begin
                    we       <= 1'b1;
                    rd       <= alu_hrd;
                    Rd_input <= alu_hdata;
                end
                lsu_win: begin
                    we       <= 1'b1;
                    rd       <= lsu_hrd;
                    Rd_input <= lsu_hdata;
                end
                default: begin
                    we <= 1'b0;
                end
            endcase
        end
    end

    // Registers with a write buffered or on the port; x0 never pends.
    always_comb begin
        pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_ev[i]) pend[alu_er[i]] = 1'b1;
            if (lsu_ev[i]) pend[lsu_er[i]] = 1'b1;
        end
        if (we) pend[rd] = 1'b1;
        pend[0] = 1'b0;
    end

    assign pending = pend;

endmodule

// File: doc/rv_wb_stage.md
# rv_wb_stage

Writeback stage that sits directly upstream of `rv_reg_file` and drives its single write port (`rd`, `Rd_input`, `we`). It has two result producers, the ALU and the load/store unit (LSU), each with a valid/ready handshake. Each producer is buffered in its own small FIFO. The stage arbitrates between the two FIFOs so that at most one register write issues per cycle. It also exports a pending-write mask that the issue logic uses to block hazards.

## Interface
- `ADDR_WIDTH`, default 5: register index width, matching `rv_reg_file`.
- `DATA_WIDTH`, default 32: register data width.
- `DEPTH`, default 2: entries per producer FIFO; must be a power of two and at least 2.
- `STARVE_MAX`, default 2: consecutive ALU losses that force an ALU grant.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `alu_valid`, in, 1: ALU result offered.
- `alu_ready`, out, 1: ALU FIFO can accept.
- `alu_rd`, in, ADDR_WIDTH: ALU destination register.
- `alu_data`, in, DATA_WIDTH: ALU result.
- `lsu_valid`, in, 1: LSU result offered.
- `lsu_ready`, out, 1: LSU FIFO can accept.
- `lsu_rd`, in, ADDR_WIDTH: LSU destination register.
- `lsu_data`, in, DATA_WIDTH: load data.
- `rd`, out, ADDR_WIDTH: register file write address.
- `Rd_input`, out, DATA_WIDTH: register file write data.
- `we`, out, 1: register file write enable.
- `pending`, out, 2**ADDR_WIDTH: bit i is set when a write to register i is buffered or presented.

## Operation
- **Handshake:** a transfer occurs on a rising edge where `valid && ready`.
  - `alu_ready = !alu_full` and `lsu_ready = !lsu_full`. Both are decoded from registered state only, with no combinational path from `*_valid`.
  - `valid` must hold its value, and `rd`/`data` must stay stable, until the transfer completes.
- **x0 filtering:** a transfer with `*_rd == 0` is accepted but discarded. It is not written into the FIFO and never produces `we`.
- **Arbitration:** happens once per cycle between the FIFO heads.
  - Only one head valid: that head wins.
  - Both heads valid: the LSU wins, unless `starve_cnt == STARVE_MAX`, in which case the ALU wins.
- **`starve_cnt` update:**
  - Increments when the ALU head is valid and loses.
  - Clears when the ALU wins or the ALU FIFO is empty.
  - Saturates at `STARVE_MAX`.
- **Output register:** the winning head is popped and loaded into `rd`/`Rd_input` with `we=1`. If there is no winner, `we=0`, and `rd`/`Rd_input` hold their previous values.
- **Pending mask:** `pending` is the OR of the one-hot decodes of `rd` across:
  - all valid entries in both FIFOs, and
  - the output register when `we=1`.

  `pending[0]` is always 0. The mask is a combinational function of registered state.
- **Ordering:** upstream never issues a second write to a register whose `pending` bit is set. The stage therefore does not enforce ordering between writes to the same `rd`; it only preserves FIFO order within each producer.
- **Simultaneous push and pop on one FIFO:** both take effect. A full FIFO that pops in a cycle still shows `ready=0` in that cycle.

## Timing
- **Reset values** (asynchronous on `rst_n=0`): `we=0`, `rd=0`, `Rd_input=0`, both FIFOs empty, `starve_cnt=0`. As a result, `alu_ready=1`, `lsu_ready=1`, and `pending=0`.
- **Latency:** a result accepted at edge N is written to the FIFO at N. It can pop at N+1 and shows `we=1` from N+1 until N+2. `rv_reg_file` commits it at edge N+2. The minimum accept-to-commit time is 2 edges.
- **Throughput:** one write per cycle sustained. Each producer sustains one transfer per cycle while its FIFO drains at least as fast as it fills.
- **Reset mid-operation:** all buffered writes are discarded, with no partial write. `we` deasserts asynchronously.
- **Wrap-around:** FIFO pointers are ADDR=$clog2(DEPTH) bits wrapping modulo DEPTH. Full and empty are distinguished by an extra count bit.

## Structure
- **Shared package `rv_pkg`:** holds `ADDR_WIDTH`/`DATA_WIDTH` defaults, the writeback entry struct (`rd`, `data`), and the `REG_X0` constant.
- **Sub-module `rv_wb_fifo`:** a parameterised synchronous FIFO with push/pop, full/empty, and a per-entry valid/`rd` view for the pending mask. It is instantiated twice. All arbitration, starvation, and output logic stays in `rv_wb_stage`.

## Test plan
1. **Reset, then a single ALU write:** `alu_rd=5`, `alu_data=32'h77` for one cycle. Required: `we=1`, `rd=5`, `Rd_input=32'h77` exactly one cycle later. `pending[5]` is set from the accept edge until after the `we` cycle.
2. **x0 drop:** `alu_rd=0`, `alu_data=32'hDEAD`. Required: accepted (`alu_ready=1`), `we` stays 0, `pending=0`.
3. **Simultaneous offers:** ALU `rd=2`/`0x11` and LSU `rd=3`/`0x22` in the same cycle. Required: write order is `rd=3` then `rd=2`, on consecutive cycles.
4. **Starvation:** LSU streams `rd=4..9` every cycle while ALU holds `rd=10`/`0xA`. Required: the ALU write issues at the third contested cycle (after 2 LSU wins), and no LSU write is lost.
5. **Backpressure:** LSU held continuously valid while the ALU pushes 3 entries back-to-back with `DEPTH=2`. Required: `alu_ready=0` after 2 accepts, the third entry waits for `ready`, and all 3 ALU writes appear in order.
6. **Reset mid-stream:** assert `rst_n=0` with both FIFOs full. Required: `we=0` immediately, `pending=0`, both readys 1 after release, and no stale write afterwards.
